// File: rtl/mmio_pkg.sv
// Shared address map, parameter defaults and address decode for the data memory / IO block.
package mmio_pkg;

  localparam int unsigned RAM_WORDS_DEFAULT = 4096;
  localparam int unsigned PRESCALE_DEFAULT  = 50000;

  localparam logic [14:0] ADDR_SW    = 15'h6000;
  localparam logic [14:0] ADDR_KEY   = 15'h6001;
  localparam logic [14:0] ADDR_LED   = 15'h6002;
  localparam logic [14:0] ADDR_TIMER = 15'h6003;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_SW,
    SEL_KEY,
    SEL_LED,
    SEL_TIMER
  } sel_e;

  // RAM occupies the bottom of the map; anything else not listed decodes to SEL_NONE.
  function automatic sel_e decode_addr(input logic [14:0] addr, input int unsigned ram_words);
    sel_e sel;
    sel = SEL_NONE;
    if ({17'b0, addr} < ram_words) begin
      sel = SEL_RAM;
    end else begin
      case (addr)
        ADDR_SW:    sel = SEL_SW;
        ADDR_KEY:   sel = SEL_KEY;
        ADDR_LED:   sel = SEL_LED;
        ADDR_TIMER: sel = SEL_TIMER;
        default:    sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/input_sync.sv
// Two-flop synchronizer for one asynchronous input, with optional falling-edge detect
// on the synchronized value.
module input_sync #(
  parameter bit RESET_VAL = 1'b0,
  parameter bit DETECT    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic fall
);

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

  generate
    if (DETECT) begin : g_edge
      // Edges are only trusted once both stages hold real samples, so an input
      // already low when reset releases is not mistaken for a fresh transition.
      logic [1:0] arm_q, arm_d;

      always_comb begin
        arm_d = {arm_q[0], 1'b1};
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          arm_q <= 2'b00;
        end else begin
          arm_q <= arm_d;
        end
      end

      assign fall = arm_q[1] & sync_q[1] & ~sync_q[0];
    end else begin : g_no_edge
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/data_memory_io.sv
// CPU data memory: word RAM with zero-latency read plus memory-mapped switches,
// sticky key-press flags, LED register and a prescaled free-running timer.
module data_memory_io
  import mmio_pkg::*;
#(
  parameter int unsigned RAM_WORDS = RAM_WORDS_DEFAULT,
  parameter int unsigned PRESCALE  = PRESCALE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] data_addr,
  input  logic [15:0] out_m,
  input  logic        write_m,
  input  logic [1:0]  key,
  input  logic [3:0]  sw,
  output logic [15:0] in_m,
  output logic [9:0]  leds
);

  localparam int AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  sel_e           sel;
  logic [AW-1:0]  ram_idx;
  logic [15:0]    ram [RAM_WORDS];
  logic [15:0]    ram_rdata;

  logic [3:0]     sw_sync;
  logic [3:0]     sw_fall_unused;
  logic [1:0]     key_sync_unused;
  logic [1:0]     key_press;

  logic [9:0]       leds_q, leds_d;
  logic [1:0]       kp_q, kp_d;
  logic [15:0]      timer_q, timer_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;
  logic             wr_en;

  assign sel     = decode_addr(data_addr, RAM_WORDS);
  assign ram_idx = data_addr[AW-1:0];
  assign wr_en   = write_m & ~reset;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      input_sync #(.RESET_VAL(1'b1), .DETECT(1'b1)) u_key_sync (
        .clk   (clk),
        .reset (reset),
        .d     (key[gi]),
        .q     (key_sync_unused[gi]),
        .fall  (key_press[gi])
      );
    end
    for (gi = 0; gi < 4; gi++) begin : g_sw
      input_sync #(.RESET_VAL(1'b0), .DETECT(1'b0)) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw[gi]),
        .q     (sw_sync[gi]),
        .fall  (sw_fall_unused[gi])
      );
    end
  endgenerate

  // RAM is deliberately left out of reset so program data survives a CPU reset.
  always_ff @(posedge clk) begin
    if (wr_en && sel == SEL_RAM) begin
      ram[ram_idx] <= out_m;
    end
  end

  assign ram_rdata = ram[ram_idx];

  always_comb begin
    in_m = 16'h0000;
    case (sel)
      SEL_RAM:   in_m = ram_rdata;
      SEL_SW:    in_m = {12'b0, sw_sync};
      SEL_KEY:   in_m = {14'b0, kp_q};
      SEL_LED:   in_m = {6'b0, leds_q};
      SEL_TIMER: in_m = timer_q;
      default:   in_m = 16'h0000;
    endcase
  end

  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    leds_d  = leds_q;
    kp_d    = kp_q;
    timer_d = timer_q;
    pre_d   = tick ? '0 : pre_q + 1'b1;
    if (tick) begin
      timer_d = timer_q + 16'd1;
    end

    if (wr_en && sel == SEL_LED) begin
      leds_d = out_m[9:0];
    end
    if (wr_en && sel == SEL_KEY) begin
      kp_d = kp_q & ~out_m[1:0];
    end
    // A press in the same cycle as a clear wins.
    kp_d = kp_d | key_press;
    if (wr_en && sel == SEL_TIMER) begin
      timer_d = out_m;
      pre_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q  <= '0;
      kp_q    <= '0;
      timer_q <= '0;
      pre_q   <= '0;
    end else begin
      leds_q  <= leds_d;
      kp_q    <= kp_d;
      timer_q <= timer_d;
      pre_q   <= pre_d;
    end
  end

  assign leds = leds_q;

endmodule

// File: tb/tb_data_memory_io.sv
// Directed bench for data_memory_io: RAM, switch/key/LED/timer registers and reset behaviour.
`timescale 1ns/1ps
module tb_data_memory_io;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] data_addr;
  logic [15:0] out_m;
  logic        write_m;
  logic [1:0]  key;
  logic [3:0]  sw;
  logic [15:0] in_m;
  logic [9:0]  leds;

  int pass_cnt  = 0;
  int check_cnt = 0;

  data_memory_io #(.RAM_WORDS(4096), .PRESCALE(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_addr (data_addr),
    .out_m     (out_m),
    .write_m   (write_m),
    .key       (key),
    .sw        (sw),
    .in_m      (in_m),
    .leds      (leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    check_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("check %-16s got %04h exp %04h ok", tag, got, exp);
    end else begin
      $display("FAIL %-16s got %04h exp %04h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input string tag, input logic [14:0] addr, input logic [15:0] exp);
    write_m   = 1'b0;
    data_addr = addr;
    #0.2;
    check(tag, in_m, exp);
  endtask

  task automatic wr(input logic [14:0] addr, input logic [15:0] data);
    data_addr = addr;
    out_m     = data;
    write_m   = 1'b1;
    step(1);
    write_m   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; data_addr = '0; out_m = '0; write_m = 1'b0; key = 2'b11; sw = 4'b0000;
    step(3);
    reset = 1'b0;

    // Reset state
    rd("rst_sw",    15'h6000, 16'h0000);
    rd("rst_key",   15'h6001, 16'h0000);
    rd("rst_led",   15'h6002, 16'h0000);
    rd("rst_timer", 15'h6003, 16'h0000);

    // RAM write/read and read-during-write
    wr(15'h0005, 16'h1111);
    data_addr = 15'h0005; out_m = 16'h1234; write_m = 1'b1;
    #0.2;
    check("ram_rdw_old", in_m, 16'h1111);
    step(1);
    rd("ram_new", 15'h0005, 16'h1234);
    wr(15'h0000, 16'h0F0F);
    wr(15'h0FFF, 16'hBEEF);
    rd("ram_top", 15'h0FFF, 16'hBEEF);
    wr(15'h1000, 16'h5555);
    rd("ram_above", 15'h1000, 16'h0000);
    rd("ram_no_alias", 15'h0000, 16'h0F0F);

    // LED register keeps only 10 bits
    wr(15'h6002, 16'hFFFF);
    rd("led_rd", 15'h6002, 16'h03FF);
    check("led_port", {6'b0, leds}, 16'h03FF);

    // Switches and unmapped / read-only writes
    sw = 4'b1010;
    step(2);
    rd("sw_rd", 15'h6000, 16'h000A);
    rd("unmapped_rd", 15'h7000, 16'h0000);
    wr(15'h7000, 16'hAAAA);
    wr(15'h6000, 16'hAAAA);
    rd("sw_ro", 15'h6000, 16'h000A);
    rd("led_keep", 15'h6002, 16'h03FF);
    rd("key_keep", 15'h6001, 16'h0000);
    rd("unmapped_6004", 15'h6004, 16'h0000);

    // Timer wrap with PRESCALE=4
    wr(15'h6003, 16'hFFFF);
    rd("timer_load", 15'h6003, 16'hFFFF);
    step(3);
    rd("timer_hold", 15'h6003, 16'hFFFF);
    step(1);
    rd("timer_wrap", 15'h6003, 16'h0000);
    step(4);
    rd("timer_inc", 15'h6003, 16'h0001);

    // Key 0 press, clear, re-press
    key[0] = 1'b0;
    step(2);
    rd("key0_press", 15'h6001, 16'h0001);
    step(8);
    key[0] = 1'b1;
    rd("key0_sticky", 15'h6001, 16'h0001);
    wr(15'h6001, 16'h0001);
    rd("key0_clear", 15'h6001, 16'h0000);
    step(3);
    rd("key0_release", 15'h6001, 16'h0000);
    key[0] = 1'b0;
    step(2);
    rd("key0_repress", 15'h6001, 16'h0001);
    key[0] = 1'b1;
    step(3);
    wr(15'h6001, 16'h0001);

    // Press and clear of key 1 in the same cycle
    key[1] = 1'b0;
    step(1);
    rd("key1_pending", 15'h6001, 16'h0000);
    wr(15'h6001, 16'h0002);
    rd("key1_prio", 15'h6001, 16'h0002);
    key[1] = 1'b1;
    step(3);
    wr(15'h6001, 16'h0002);
    rd("key_cleared", 15'h6001, 16'h0000);

    // One-cycle reset with a held key and a RAM write attempt
    key = 2'b10;
    step(3);
    data_addr = 15'h0005; out_m = 16'hDEAD; write_m = 1'b1; reset = 1'b1;
    step(1);
    reset = 1'b0; write_m = 1'b0;
    check("rst_led_port", {6'b0, leds}, 16'h0000);
    rd("rst2_led", 15'h6002, 16'h0000);
    rd("rst2_timer", 15'h6003, 16'h0000);
    rd("rst2_sw", 15'h6000, 16'h0000);
    rd("ram_kept", 15'h0005, 16'h1234);
    step(5);
    rd("held_no_press", 15'h6001, 16'h0000);
    rd("sw_resync", 15'h6000, 16'h000A);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got %0d exp %0d", check_cnt, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_memory_io.md
DATA_MEMORY_IO -- requirements
Module: data_memory_io

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 4096: number of 16-bit data RAM words, mapped at address 0x0000 upward.
REQ-002 SHALL have parameter PRESCALE, default 50000: clk cycles per timer tick.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_addr  input  15  word address from the CPU A register.
REQ-006 SHALL have port out_m  input  16  write data from the CPU.
REQ-007 SHALL have port write_m  input  1  write strobe; a write commits on the rising edge where write_m=1.
REQ-008 SHALL have port key  input  2  raw push-buttons, active-low, asynchronous to clk.
REQ-009 SHALL have port sw  input  4  raw slide switches, asynchronous to clk.
REQ-010 SHALL have port in_m  output  16  read data returned to the CPU.
REQ-011 SHALL have port leds  output  10  LED register contents.

Function
REQ-012 SHALL drive in_m combinationally from data_addr and current state, with zero-cycle read latency, because the CPU consumes in_m in the same cycle.
REQ-013 SHALL use this address map: 0x0000..RAM_WORDS-1 RAM (read/write); 0x6000 SW (read-only); 0x6001 KEY (read, write-1-to-clear); 0x6002 LED (read/write); 0x6003 TIMER (read/write).
REQ-014 SHALL return 0x0000 on a read of any unmapped address, and SHALL ignore writes to unmapped addresses and to 0x6000.
REQ-015 SHALL, on a read-during-write to the same address, return the pre-write value in that cycle; the new value is visible from the next cycle.
REQ-016 SHALL pass sw through a two-flop synchronizer and read it at 0x6000 as {12'b0, sw_sync}.
REQ-017 SHALL pass each key bit through a two-flop synchronizer; a 1->0 transition of the synced value is a press, which sets sticky bit kp[i].
REQ-018 SHALL read 0x6001 as {14'b0, kp}; a write to 0x6001 clears each kp[i] for which out_m[i]=1.
REQ-019 SHALL give press priority: when a press and a clear of the same bit occur in the same cycle, that bit ends up set.
REQ-020 SHALL load leds <= out_m[9:0] on a write to 0x6002, and SHALL read 0x6002 as {6'b0, leds}.
REQ-021 SHALL run prescaler counter pre from 0 to PRESCALE-1 and then wrap to 0; on the wrap cycle, timer increments modulo 2^16 (0xFFFF -> 0x0000).
REQ-022 SHALL, on a write to 0x6003, load timer <= out_m and pre <= 0; a write takes priority over a coincident tick.
REQ-023 SHALL read 0x6003 as the timer value.
REQ-024 SHALL perform no action for a write to a RAM address at or above RAM_WORDS and below 0x6000.

Reset
REQ-025 SHALL, on a cycle with reset=1, set leds=0, kp=0, timer=0, pre=0, key synchronizer flops=1 (released), and sw synchronizer flops=0.
REQ-026 SHALL ignore write_m in any cycle where reset=1.
REQ-027 SHALL NOT clear RAM contents on reset.
REQ-028 SHALL make in_m follow REQ-012 during reset, reflecting the reset values from the cycle after reset.
REQ-029 SHALL NOT record a key press on the release of reset while a key is held, because the synchronizers initialise to released.

Structure
REQ-030 SHALL place the address constants (ADDR_SW, ADDR_KEY, ADDR_LED, ADDR_TIMER) and the RAM_WORDS and PRESCALE defaults in shared package mmio_pkg.
REQ-031 SHALL implement the two-flop synchronizer plus falling-edge detect as sub-module input_sync, with one instance per key bit; sw uses synchronizer-only instances of input_sync.
REQ-032 SHALL implement RAM as an asynchronous-read, synchronous-write array.

Verification
REQ-033 SHALL cover: write 0x1234 to 0x0005, then read 0x0005 -> 0x1234; in the same-cycle read-during-write, read the old value.
REQ-034 SHALL cover: key[0] held low for 10 cycles -> 0x6001 reads 0x0001 by the 3rd cycle after the falling edge; write 0x0001 to 0x6001 -> reads 0x0000; release and re-press -> 0x0001 again.
REQ-035 SHALL cover: a press and a clear of bit 1 landing in the same cycle -> 0x6001 reads 0x0002.
REQ-036 SHALL cover, with PRESCALE=4: write 0xFFFF to 0x6003 -> after 4 cycles reads 0x0000, after 8 cycles reads 0x0001.
REQ-037 SHALL cover: write 0x03FF to 0x6002 -> leds=0x3FF; assert reset for one cycle -> leds=0, and a previously written RAM word is unchanged.
REQ-038 SHALL cover: read 0x7000 -> 0x0000; write 0xAAAA to 0x7000 and then 0x6000 -> no state change, and sw=4'b1010 reads 0x000A.
